pixel_stream_writer: RTL and testbench



---
 rtl/pixel_stream_writer.sv | 154 +++++++++++++++
 tb/tb_pixel_stream_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_writer.sv
// Packs RGB565 pixel pairs into 32-bit words and streams them to the SRAM memory manager.
// Optional dropped-pixel counter enabled by defining PIXEL_STREAM_WRITER_DROP_COUNT_EN.
module pixel_stream_writer #(
    parameter logic [17:0] BASE_ADDR   = 18'd0,
    parameter int          FRAME_WORDS = 38400,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        mem_req,
    output logic        mem_wren,
    output logic [17:0] mem_address,
    output logic [31:0] mem_data_write,
    input  logic        mem_pause,
    output logic        frame_done,
    output logic        overflow,
    output logic [15:0] drop_count,
    output logic        busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state_reg;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_idx_next;
    logic [CW-1:0] count_reg;
    logic [31:0]   head_reg;
    logic [17:0]   addr_reg;
    logic [15:0]   low_reg;
    logic          have_low_reg;
    logic [IW-1:0] push_idx_reg;
    logic          overflow_reg;

    logic          fifo_full;
    logic          fifo_empty;
    logic          active;
    logic          pop;
    logic          accept;
    logic          push;
    logic          last_push;
    logic          ovf_event;
    logic [31:0]   push_word;

    assign fifo_full   = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count_reg == '0);
    assign active      = (state_reg == RUN) || (state_reg == DRAIN);
    assign mem_req     = active && !fifo_empty;
    assign pop         = mem_req && !mem_pause;
    assign pix_ready   = (state_reg == RUN) && (!fifo_full || pop);
    assign accept      = pix_valid && pix_ready;
    assign push        = accept && have_low_reg;
    assign last_push   = push && (push_idx_reg == IW'(FRAME_WORDS - 1));
    assign ovf_event   = (state_reg == RUN) && pix_valid && !pix_ready;
    assign push_word   = {pix_data, low_reg};
    assign rd_idx_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    assign mem_wren       = mem_req;
    assign mem_address    = addr_reg;
    assign mem_data_write = head_reg;
    assign frame_done     = (state_reg == DONE);
    assign overflow       = overflow_reg;
    assign busy           = active;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_word;
        end
    end

    // Registered head read; a word written into the slot being read is forwarded directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg <= '0;
        end else if (push && (wr_ptr_reg == rd_idx_next)) begin
            head_reg <= push_word;
        end else begin
            head_reg <= fifo_mem[rd_idx_next];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            addr_reg     <= BASE_ADDR;
            low_reg      <= '0;
            have_low_reg <= 1'b0;
            push_idx_reg <= '0;
            overflow_reg <= 1'b0;
        end else if (frame_start) begin
            state_reg    <= RUN;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            addr_reg     <= BASE_ADDR;
            have_low_reg <= 1'b0;
            push_idx_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_idx_next;
            count_reg  <= count_reg + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                push_idx_reg <= push_idx_reg + 1'b1;
            end
            if (pop) begin
                addr_reg <= addr_reg + 18'd1;
            end
            if (accept) begin
                have_low_reg <= !have_low_reg;
                if (!have_low_reg) begin
                    low_reg <= pix_data;
                end
            end
            if (ovf_event) begin
                overflow_reg <= 1'b1;
            end
            case (state_reg)
                RUN:     if (last_push) state_reg <= DRAIN;
                DRAIN:   if (pop && (count_reg == CW'(1))) state_reg <= DONE;
                DONE:    state_reg <= IDLE;
                default: state_reg <= state_reg;
            endcase
        end
    end

`ifdef PIXEL_STREAM_WRITER_DROP_COUNT_EN
    logic [15:0] drop_count_reg;

    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            drop_count_reg <= '0;
        end else if (ovf_event && (drop_count_reg != 16'hFFFF)) begin
            drop_count_reg <= drop_count_reg + 16'd1;
        end
    end

    assign drop_count = drop_count_reg;
`else
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Scoreboard bench for pixel_stream_writer: a large-frame instance and a 4-word-frame instance
// share stimulus; the instance selected by sel is checked.
module tb_pixel_stream_writer;
    localparam logic [17:0] BASE_MAIN  = 18'h00100;
    localparam logic [17:0] BASE_SMALL = 18'h3FFFE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic pix_valid = 1'b0;
    logic [15:0] pix_data = '0;
    logic mem_pause = 1'b0;
    logic sel = 1'b0;
    logic toggle_en = 1'b0;

    logic        m_ready, m_req, m_wren, m_done, m_ovf, m_busy;
    logic [17:0] m_addr;
    logic [31:0] m_data;
    logic [15:0] m_drop;
    logic        s_ready, s_req, s_wren, s_done, s_ovf, s_busy;
    logic [17:0] s_addr;
    logic [31:0] s_data;
    logic [15:0] s_drop;

    logic        sel_ready, sel_req, sel_wren, sel_done, sel_ovf, sel_busy;
    logic [17:0] sel_addr, sel_base;
    logic [31:0] sel_data;
    logic [15:0] sel_drop;

    int n_checks = 0;
    int n_fail = 0;
    int n_popped = 0;
    int done_cnt = 0;
    logic [31:0] exp_q [$];
    logic [17:0] exp_addr = BASE_MAIN;
    logic [15:0] low_model = '0;
    logic        have_low_model = 1'b0;

    always #5 clk = ~clk;

    pixel_stream_writer #(.BASE_ADDR(BASE_MAIN), .FRAME_WORDS(64), .FIFO_DEPTH(8)) u_main (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(m_ready), .mem_req(m_req), .mem_wren(m_wren),
        .mem_address(m_addr), .mem_data_write(m_data), .mem_pause(mem_pause),
        .frame_done(m_done), .overflow(m_ovf), .drop_count(m_drop), .busy(m_busy)
    );

    pixel_stream_writer #(.BASE_ADDR(BASE_SMALL), .FRAME_WORDS(4), .FIFO_DEPTH(8)) u_small (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(s_ready), .mem_req(s_req), .mem_wren(s_wren),
        .mem_address(s_addr), .mem_data_write(s_data), .mem_pause(mem_pause),
        .frame_done(s_done), .overflow(s_ovf), .drop_count(s_drop), .busy(s_busy)
    );

    always_comb begin
        sel_ready = sel ? s_ready : m_ready;
        sel_req   = sel ? s_req   : m_req;
        sel_wren  = sel ? s_wren  : m_wren;
        sel_done  = sel ? s_done  : m_done;
        sel_ovf   = sel ? s_ovf   : m_ovf;
        sel_busy  = sel ? s_busy  : m_busy;
        sel_addr  = sel ? s_addr  : m_addr;
        sel_data  = sel ? s_data  : m_data;
        sel_drop  = sel ? s_drop  : m_drop;
        sel_base  = sel ? BASE_SMALL : BASE_MAIN;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: pixel pairs accepted by the handshake become expected words; requests are compared.
    always @(negedge clk) begin
        if (sel_req) begin
            if (exp_q.size() == 0) begin
                chk("spurious_req", {31'd0, sel_req}, 32'd0);
            end else begin
                chk("wr_data", sel_data, exp_q[0]);
                chk("wr_addr", {14'd0, sel_addr}, {14'd0, exp_addr});
                chk("wr_wren", {31'd0, sel_wren}, 32'd1);
                if (!mem_pause && !rst && !frame_start) begin
                    $display("word %0d addr %h data %h", n_popped, sel_addr, sel_data);
                    void'(exp_q.pop_front());
                    exp_addr = exp_addr + 18'd1;
                    n_popped++;
                end
            end
        end
        if (pix_valid && sel_ready && !rst && !frame_start) begin
            if (have_low_model) begin
                exp_q.push_back({pix_data, low_model});
                have_low_model = 1'b0;
            end else begin
                low_model = pix_data;
                have_low_model = 1'b1;
            end
        end
        if (sel_done) done_cnt++;
        if (rst || frame_start) begin
            exp_q.delete();
            have_low_model = 1'b0;
            exp_addr = sel_base;
        end
    end

    always @(posedge clk) begin
        if (toggle_en) begin
            #1 mem_pause = ~mem_pause;
        end
    end

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic send_pix(input logic [15:0] d);
        bit ok = 1'b0;
        pix_valid = 1'b1;
        pix_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = sel_ready;
            @(posedge clk); #1;
        end
        if (!ok) chk("pix_timeout", {31'd0, sel_ready}, 32'd1);
    endtask

    task automatic wait_req();
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = sel_req;
        end
        chk("req_timeout", {31'd0, sel_req}, 32'd1);
    endtask

    task automatic check_reset(input logic [17:0] base);
        chk("rst_ready", {31'd0, sel_ready}, 32'd0);
        chk("rst_req",   {31'd0, sel_req},   32'd0);
        chk("rst_wren",  {31'd0, sel_wren},  32'd0);
        chk("rst_addr",  {14'd0, sel_addr},  {14'd0, base});
        chk("rst_data",  sel_data,           32'd0);
        chk("rst_done",  {31'd0, sel_done},  32'd0);
        chk("rst_ovf",   {31'd0, sel_ovf},   32'd0);
        chk("rst_drop",  {16'd0, sel_drop},  32'd0);
        chk("rst_busy",  {31'd0, sel_busy},  32'd0);
    endtask

    initial begin
        int done_base;
        int exp_drop;
`ifdef PIXEL_STREAM_WRITER_DROP_COUNT_EN
        exp_drop = 5;
`else
        exp_drop = 0;
`endif
        // Reset state and first word
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset(BASE_MAIN);
        @(posedge clk); #1;
        n_popped = 0;
        pulse_frame_start();
        send_pix(16'h1111);
        send_pix(16'h2222);
        pix_valid = 1'b0;
        wait_req();
        chk("s1_data", m_data, 32'h22221111);
        chk("s1_addr", {14'd0, m_addr}, {14'd0, BASE_MAIN});
        @(posedge clk); #1;

        // Pause held: FIFO fills at 8 words, then pixels are refused
        mem_pause = 1'b1;
        for (int i = 0; i < 16; i++) send_pix(16'h3000 + 16'(i));
        pix_data = 16'h3010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s3_ready_low", {31'd0, sel_ready}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("s3_ovf", {31'd0, sel_ovf}, 32'd1);
        chk("s3_drop", {16'd0, sel_drop}, exp_drop);
        chk("s3_req", {31'd0, sel_req}, 32'd1);
        @(posedge clk); #1;

        // Pause toggling on a full FIFO while pixels keep coming
        toggle_en = 1'b1;
        for (int i = 0; i < 44; i++) send_pix(16'h3010 + 16'(i));
        pix_valid = 1'b0;
        toggle_en = 1'b0;
        @(posedge clk); #2;
        mem_pause = 1'b0;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("s4_drained", exp_q.size(), 32'd0);
        chk("s4_words", n_popped, 32'd31);
        chk("s4_req_idle", {31'd0, sel_req}, 32'd0);
        @(posedge clk); #1;

        // Restart mid-frame after 3 buffered words
        mem_pause = 1'b1;
        for (int i = 0; i < 6; i++) send_pix(16'h5000 + 16'(i));
        pix_valid = 1'b0;
        pulse_frame_start();
        @(negedge clk);
        chk("s5_ovf_clr", {31'd0, sel_ovf}, 32'd0);
        chk("s5_drop_clr", {16'd0, sel_drop}, 32'd0);
        chk("s5_req_flushed", {31'd0, sel_req}, 32'd0);
        @(posedge clk); #1;
        send_pix(16'hAAAA);
        send_pix(16'hBBBB);
        pix_valid = 1'b0;
        mem_pause = 1'b0;
        wait_req();
        chk("s5_data", m_data, 32'hBBBBAAAA);
        chk("s5_addr", {14'd0, m_addr}, {14'd0, BASE_MAIN});
        @(posedge clk); #1;

        // Short frame: 4 words with address wrap, one frame_done
        sel = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset(BASE_SMALL);
        @(posedge clk); #1;
        n_popped = 0;
        done_base = done_cnt;
        pulse_frame_start();
        for (int i = 0; i < 8; i++) send_pix(16'h6000 + 16'(i));
        pix_data = 16'h6FFF;
        @(negedge clk);
        chk("s2_ready_after_frame", {31'd0, sel_ready}, 32'd0);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        @(negedge clk);
        chk("s2_no_ovf", {31'd0, sel_ovf}, 32'd0);
        for (int i = 0; i < 40 && done_cnt == done_base; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("s2_done_pulses", done_cnt - done_base, 32'd1);
        chk("s2_words", n_popped, 32'd4);
        chk("s2_idle", {31'd0, sel_busy}, 32'd0);
        @(posedge clk); #1;

        // Reset while draining
        mem_pause = 1'b1;
        pulse_frame_start();
        for (int i = 0; i < 8; i++) send_pix(16'h7000 + 16'(i));
        pix_valid = 1'b0;
        @(negedge clk);
        chk("s6_busy", {31'd0, sel_busy}, 32'd1);
        chk("s6_req", {31'd0, sel_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset(BASE_SMALL);
        done_base = done_cnt;
        @(posedge clk); #1;
        mem_pause = 1'b0;
        repeat (10) @(negedge clk);
        chk("s6_no_done", done_cnt - done_base, 32'd0);
        chk("s6_no_req", {31'd0, sel_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
